// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } rx_state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  // Clocks per sample tick; zero means the clock is too slow for the baud rate.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baudrate,
                                           input int unsigned oversample);
    return clk_freq / (baudrate * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Sample-tick generator: one-clk tick every DIV clocks, restartable on a start edge.
module uart_baud_tick #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic          tick_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (restart) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (cnt_q == CW'(DIV - 1)) begin
      cnt_q  <= '0;
      tick_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
      tick_q <= 1'b0;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with 3-sample majority vote, parity/stop checking
// and break suppression after a framing error.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUDRATE   = 115_200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 di,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned DIV  = calc_div(CLK_FREQ, BAUDRATE, OVERSAMPLE);
  localparam int unsigned SW   = $clog2(OVERSAMPLE);
  localparam int unsigned HALF = OVERSAMPLE / 2;

  if (DIV < 1) begin : g_bad_div
    $error("uart_rx_os: CLK_FREQ too low for BAUDRATE*OVERSAMPLE");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_rx_os: DATA_BITS must be 5..9");
  end
  if (PARITY > 2) begin : g_bad_par
    $error("uart_rx_os: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_rx_os: STOP_BITS must be 1 or 2");
  end
  if ((OVERSAMPLE % 2) != 0 || OVERSAMPLE < 8) begin : g_bad_os
    $error("uart_rx_os: OVERSAMPLE must be even and >= 8");
  end

  rx_state_e            state_q, state_d;
  logic [SW-1:0]        sample_q, sample_d;
  logic [3:0]           bitcnt_q, bitcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [1:0]           vote_q, vote_d;
  logic                 par_q, par_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 busy_q, busy_d;
  logic                 sync1_q, sync2_q, prev_q;
  logic                 di_s, fall_c, maj_c, mid_c, end_c, ferr_now_c;
  logic                 restart_c, tick;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart_c),
    .tick    (tick)
  );

  assign di_s   = sync2_q;
  assign fall_c = prev_q & ~di_s;
  assign maj_c  = (vote_q[0] & vote_q[1]) | (vote_q[0] & di_s) | (vote_q[1] & di_s);
  assign mid_c  = tick && (sample_q == SW'(HALF + 1));
  assign end_c  = tick && (sample_q == SW'(OVERSAMPLE - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sample_q   <= '0;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      vote_q     <= '0;
      par_q      <= 1'b0;
      ferr_acc_q <= 1'b0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      sample_q   <= sample_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      vote_q     <= vote_d;
      par_q      <= par_d;
      ferr_acc_q <= ferr_acc_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      busy_q     <= busy_d;
      sync1_q    <= di;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    sample_d   = sample_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    vote_d     = vote_q;
    par_d      = par_q;
    ferr_acc_d = ferr_acc_q;
    valid_d    = 1'b0;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    restart_c  = 1'b0;
    ferr_now_c = ferr_acc_q | ~maj_c;

    // Per-bit sample position and the two early votes of the majority window.
    if (tick) begin
      sample_d = (sample_q == SW'(OVERSAMPLE - 1)) ? '0 : sample_q + 1'b1;
      if (sample_q == SW'(HALF - 1)) vote_d[0] = di_s;
      if (sample_q == SW'(HALF))     vote_d[1] = di_s;
    end

    case (state_q)
      S_IDLE: begin
        sample_d = '0;
        if (fall_c) begin
          state_d    = S_START;
          restart_c  = 1'b1;
          ferr_acc_d = 1'b0;
          bitcnt_d   = '0;
        end
      end
      S_START: begin
        if (mid_c && maj_c) begin
          state_d = S_IDLE;
        end else if (end_c) begin
          state_d  = S_DATA;
          bitcnt_d = '0;
        end
      end
      S_DATA: begin
        if (mid_c) shift_d = {maj_c, shift_q[DATA_BITS-1:1]};
        if (end_c) begin
          if (bitcnt_q == 4'(DATA_BITS - 1)) begin
            state_d  = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
            bitcnt_d = '0;
          end else begin
            bitcnt_d = bitcnt_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (mid_c) par_d = maj_c;
        if (end_c) begin
          state_d  = S_STOP;
          bitcnt_d = '0;
        end
      end
      S_STOP: begin
        // Final stop bit completes the frame at its midpoint to allow early resync.
        if (mid_c) begin
          if (bitcnt_q == 4'(STOP_BITS - 1)) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            perr_d  = (PARITY != PAR_NONE) &&
                      ((^shift_q) ^ par_q ^ (PARITY == PAR_ODD));
            ferr_d  = ferr_now_c;
            state_d = ferr_now_c ? S_WAIT_HIGH : S_IDLE;
          end else begin
            ferr_acc_d = ferr_now_c;
          end
        end else if (end_c) begin
          bitcnt_d = bitcnt_q + 1'b1;
        end
      end
      S_WAIT_HIGH: begin
        if (di_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign data_out   = data_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: 8N1 instance and an even-parity instance.
module tb_uart_rx_os;

  localparam int unsigned OS = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       di_a = 1'b1;
  logic       di_b = 1'b1;
  logic [7:0] data_a, data_b;
  logic       valid_a, perr_a, ferr_a, busy_a;
  logic       valid_b, perr_b, ferr_b, busy_b;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  uart_rx_os #(
    .CLK_FREQ(16_000_000), .BAUDRATE(1_000_000), .OVERSAMPLE(OS),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .di(di_a), .data_out(data_a), .valid(valid_a),
    .parity_err(perr_a), .frame_err(ferr_a), .busy(busy_a)
  );

  uart_rx_os #(
    .CLK_FREQ(16_000_000), .BAUDRATE(1_000_000), .OVERSAMPLE(OS),
    .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .di(di_b), .data_out(data_b), .valid(valid_b),
    .parity_err(perr_b), .frame_err(ferr_b), .busy(busy_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitors: every valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (valid_a === 1'b1) begin
      if (q_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid_a actual=%0h expected=none", data_a);
      end else begin
        e = q_a.pop_front();
        chk("a_data", 32'(data_a), 32'(e.data));
        chk("a_parity_err", 32'(perr_a), 32'(e.perr));
        chk("a_frame_err", 32'(ferr_a), 32'(e.ferr));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (valid_b === 1'b1) begin
      if (q_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid_b actual=%0h expected=none", data_b);
      end else begin
        e = q_b.pop_front();
        chk("b_data", 32'(data_b), 32'(e.data));
        chk("b_parity_err", 32'(perr_b), 32'(e.perr));
        chk("b_frame_err", 32'(ferr_b), 32'(e.ferr));
      end
    end
  end

  // Drives one frame, one line value per clock; optional single-cycle inversion and reset pulse.
  task automatic drive_frame(input bit sel, input logic [7:0] d, input bit has_par,
                             input bit par, input bit stop, input int inv_at, input int rst_at);
    logic [11:0] bits;
    int          nb;
    logic        v;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
    nb = 9;
    if (has_par) begin
      bits[nb] = par;
      nb++;
    end
    bits[nb] = stop;
    nb++;
    for (int c = 0; c < nb * int'(OS); c++) begin
      @(negedge clk);
      v = bits[c / int'(OS)] ^ (c == inv_at);
      if (sel) di_b = v; else di_a = v;
      if (c == rst_at) rst_n = 1'b0;
      if (c == rst_at + 2) rst_n = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    // Reset state
    idle(3);
    chk("rst_data", 32'(data_a), 32'h0);
    chk("rst_valid", 32'(valid_a), 32'h0);
    chk("rst_parity_err", 32'(perr_a), 32'h0);
    chk("rst_frame_err", 32'(ferr_a), 32'h0);
    chk("rst_busy", 32'(busy_a), 32'h0);
    rst_n = 1'b1;
    idle(20);

    // 8N1 0xA5
    q_a.push_back('{data: 8'hA5, perr: 1'b0, ferr: 1'b0});
    drive_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, -1, -1);
    idle(32);

    // Even parity: 0x03 with parity 1 is wrong, 0x07 with parity 1 is right
    q_b.push_back('{data: 8'h03, perr: 1'b1, ferr: 1'b0});
    drive_frame(1'b1, 8'h03, 1'b1, 1'b1, 1'b1, -1, -1);
    idle(32);
    q_b.push_back('{data: 8'h07, perr: 1'b0, ferr: 1'b0});
    drive_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1, -1, -1);
    idle(32);

    // Framing error followed by a long break
    q_a.push_back('{data: 8'h55, perr: 1'b0, ferr: 1'b1});
    drive_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0, -1, -1);
    for (int c = 0; c < 20 * int'(OS); c++) begin
      @(negedge clk);
      if (c == 160) chk("break_busy_high", 32'(busy_a), 32'h1);
    end
    chk("break_busy_end", 32'(busy_a), 32'h1);
    di_a = 1'b1;
    idle(8);
    chk("break_busy_released", 32'(busy_a), 32'h0);
    idle(24);
    q_a.push_back('{data: 8'h12, perr: 1'b0, ferr: 1'b0});
    drive_frame(1'b0, 8'h12, 1'b0, 1'b0, 1'b1, -1, -1);
    idle(32);

    // Short glitch: 3 low cycles
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      di_a = (c < 3) ? 1'b0 : 1'b1;
      if (c == 6)  chk("glitch_busy_start", 32'(busy_a), 32'h1);
      if (c == 15) chk("glitch_busy_cleared", 32'(busy_a), 32'h0);
    end

    // Middle vote of data bit 3 inverted
    q_a.push_back('{data: 8'h0F, perr: 1'b0, ferr: 1'b0});
    drive_frame(1'b0, 8'h0F, 1'b0, 1'b0, 1'b1, 5 * int'(OS) - 6, -1);
    idle(32);

    // Reset during data bit 4; frame must be dropped
    drive_frame(1'b0, 8'hF0, 1'b0, 1'b0, 1'b1, -1, 5 * int'(OS) + 4);
    idle(4);
    chk("abort_data", 32'(data_a), 32'h0);
    chk("abort_valid", 32'(valid_a), 32'h0);
    chk("abort_parity_err", 32'(perr_a), 32'h0);
    chk("abort_frame_err", 32'(ferr_a), 32'h0);
    chk("abort_busy", 32'(busy_a), 32'h0);
    idle(28);
    q_a.push_back('{data: 8'h3C, perr: 1'b0, ferr: 1'b0});
    drive_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, -1, -1);
    idle(40);
    chk("hold_data", 32'(data_a), 32'h3C);

    // Every expected frame must have been seen
    chk("missing_frames_a", 32'(q_a.size()), 32'h0);
    chk("missing_frames_b", 32'(q_b.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUDRATE, default 115_200, line bit rate in bit/s.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit; even, >= 8.
REQ-004 SHALL have parameter DATA_BITS, default 8, payload width, legal 5..9.
REQ-005 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-006 SHALL have parameter STOP_BITS, default 1, stop bits checked, legal 1 or 2.
REQ-007 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-008 SHALL have port rst_n, input, 1, reset, synchronous, active-low.
REQ-009 SHALL have port di, input, 1, asynchronous serial line, idle high.
REQ-010 SHALL have port data_out, output, DATA_BITS, last received payload, LSB first on line.
REQ-011 SHALL have port valid, output, 1, one-cycle pulse marking a completed frame.
REQ-012 SHALL have port parity_err, output, 1, parity mismatch flag, qualified by valid.
REQ-013 SHALL have port frame_err, output, 1, stop-bit error flag, qualified by valid.
REQ-014 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-015 SHALL pass di through a 2-flop synchroniser; all sampling uses the synchronised signal.
REQ-016 SHALL generate a sample tick every DIV = CLK_FREQ/(BAUDRATE*OVERSAMPLE) clocks (integer division, DIV >= 1); the tick counter restarts at 0 on the start-edge detection.
REQ-017 SHALL use states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-018 SHALL in IDLE move to START on a synchronised 1->0 transition.
REQ-019 SHALL take each bit value as the majority of samples at ticks OS/2-1, OS/2 and OS/2+1 within the bit, OS = OVERSAMPLE.
REQ-020 SHALL in START return to IDLE with no outputs changed if the start-bit majority is 1 (glitch rejection); otherwise proceed to DATA.
REQ-021 SHALL shift DATA_BITS bits LSB first, then go to PARITY if PARITY != 0, else to STOP.
REQ-022 SHALL set parity_err when the received parity bit differs from the computed one (odd: the XOR of data and parity equals 1).
REQ-023 SHALL check STOP_BITS stop bits and set frame_err if any stop-bit majority is 0.
REQ-024 SHALL, one clk after the OS/2+1 sample of the final stop bit, load data_out and pulse valid for exactly one clk with parity_err/frame_err valid that cycle.
REQ-025 SHALL then enter IDLE, or WAIT_HIGH if frame_err=1, leaving WAIT_HIGH only when synchronised di = 1 (break suppression).
REQ-026 SHALL hold data_out, parity_err and frame_err stable between valid pulses.
REQ-027 SHALL fail elaboration if DIV < 1, DATA_BITS is outside 5..9, PARITY > 2, STOP_BITS is not 1 or 2, or OVERSAMPLE is odd or < 8.

Reset
REQ-028 SHALL on rst_n=0 at a clk edge force state IDLE, tick and bit counters 0, synchroniser flops 1, data_out 0, valid 0, parity_err 0, frame_err 0, busy 0.
REQ-029 SHALL abandon a frame in progress when reset is applied mid-frame, with no valid pulse for it.

Structure
REQ-030 SHALL place the state enum, parity-mode constants and a DIV-computing function in shared package uart_pkg.
REQ-031 SHALL implement the tick generator as sub-module uart_baud_tick (clk, rst_n, restart, tick).

Verification
(Bench: CLK_FREQ 16_000_000, BAUDRATE 1_000_000, OVERSAMPLE 16, so DIV=1.)
REQ-032 SHALL check 8N1 frame 0xA5 -> one valid pulse, data_out=0xA5, parity_err=0, frame_err=0.
REQ-033 SHALL check PARITY=2 (even), data 0x03 sent with parity bit 1 -> valid, data_out=0x03, parity_err=1.
REQ-034 SHALL check 0x55 with stop bit 0, then di held low 20 bit times -> one valid with frame_err=1, no further valid, busy stays 1 until di returns high; next frame 0x12 is received correctly.
REQ-035 SHALL check di low for 3 ticks only -> no valid, busy returns to 0 by the start-bit midpoint.
REQ-036 SHALL check tick OS/2 inverted inside data bit 3 of 0x0F -> data_out=0x0F (majority vote holds).
REQ-037 SHALL check rst_n low for 2 clks during data bit 4 -> all outputs 0, no valid; following frame 0x3C -> data_out=0x3C.
